apb2axi_axi_responder: RTL and testbench



---
 rtl/apb2axi_axi_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_apb2axi_axi_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_axi_responder.sv
// rtl/apb2axi_axi_responder.sv - AXI slave responder: word memory, queued INCR reads, single
// outstanding write, per-beat DECERR/injected-error responses.
module apb2axi_axi_responder #(
  parameter int TAG_W         = 4,
  parameter int AXI_ADDR_W    = 32,
  parameter int AXI_DATA_W    = 32,
  parameter int MEM_WORDS     = 64,
  parameter int AR_FIFO_DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [TAG_W-1:0]        arid,
  input  logic [AXI_ADDR_W-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [TAG_W-1:0]        rid,
  output logic [AXI_DATA_W-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [TAG_W-1:0]        awid,
  input  logic [AXI_ADDR_W-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [AXI_DATA_W-1:0]   wdata,
  input  logic [AXI_DATA_W/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [TAG_W-1:0]        bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic                    err_inj_en,
  input  logic [AXI_ADDR_W-1:0]   err_inj_addr,
  input  logic [1:0]              err_inj_resp
);

  localparam int BYTES    = AXI_DATA_W / 8;
  localparam int BYTE_LSB = $clog2(BYTES);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam int PTR_W    = $clog2(AR_FIFO_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [AXI_ADDR_W:0]   MEM_BYTES = (AXI_ADDR_W+1)'(MEM_WORDS * BYTES);
  localparam logic [AXI_ADDR_W-1:0] STRIDE    = AXI_ADDR_W'(BYTES);

  typedef enum logic {R_IDLE, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  function automatic logic [1:0] beat_resp(input logic [AXI_ADDR_W-1:0] addr,
                                           input logic                  inj_en,
                                           input logic [AXI_ADDR_W-1:0] inj_addr,
                                           input logic [1:0]            inj_resp);
    if ({1'b0, addr} >= MEM_BYTES) return RESP_DECERR;
    if (inj_en && addr == inj_addr) return inj_resp;
    return RESP_OKAY;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic [AXI_DATA_W-1:0] mem_q [MEM_WORDS];

  logic [TAG_W-1:0]      fifo_id_q   [AR_FIFO_DEPTH];
  logic [AXI_ADDR_W-1:0] fifo_addr_q [AR_FIFO_DEPTH];
  logic [7:0]            fifo_len_q  [AR_FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
  logic                  fifo_empty, fifo_full, ar_push, ar_pop;

  r_state_e              r_state_q, r_state_d;
  logic [AXI_ADDR_W-1:0] r_addr_q, r_addr_d, r_load_addr;
  logic [7:0]            r_rem_q, r_rem_d;
  logic [TAG_W-1:0]      rid_q, rid_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  r_load;

  w_state_e              w_state_q, w_state_d;
  logic [AXI_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_rem_q, w_rem_d;
  logic [TAG_W-1:0]      bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            w_beat_resp, w_acc;
  logic                  w_exp_last, mem_we;
  logic [IDX_W-1:0]      w_idx;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign arready    = !fifo_full && !areset;
  assign ar_push    = arvalid && arready;

  always_ff @(posedge aclk) begin
    if (ar_push) begin
      fifo_id_q[wr_ptr_q[PTR_W-1:0]]   <= arid;
      fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= araddr;
      fifo_len_q[wr_ptr_q[PTR_W-1:0]]  <= arlen;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (ar_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (ar_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Beat data is sampled from memory when the beat is loaded, so it stays stable under stalls.
  always_comb begin
    r_state_d   = r_state_q;
    r_addr_d    = r_addr_q;
    r_rem_d     = r_rem_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    ar_pop      = 1'b0;
    r_load      = 1'b0;
    r_load_addr = r_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (!fifo_empty) begin
          ar_pop      = 1'b1;
          r_load      = 1'b1;
          r_load_addr = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
          r_rem_d     = fifo_len_q[rd_ptr_q[PTR_W-1:0]];
          rid_d       = fifo_id_q[rd_ptr_q[PTR_W-1:0]];
          r_state_d   = R_BURST;
        end
      end
      R_BURST: begin
        if (rready) begin
          if (r_rem_q == 8'd0) begin
            r_state_d = R_IDLE;
          end else begin
            r_load      = 1'b1;
            r_load_addr = r_addr_q + STRIDE;
            r_rem_d     = r_rem_q - 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      r_addr_d = r_load_addr;
      rresp_d  = beat_resp(r_load_addr, err_inj_en, err_inj_addr, err_inj_resp);
      rdata_d  = (rresp_d == RESP_DECERR) ? '0 : mem_q[r_load_addr[BYTE_LSB +: IDX_W]];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_rem_q   <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_rem_q   <= r_rem_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign rvalid = (r_state_q == R_BURST);
  assign rlast  = rvalid && (r_rem_q == 8'd0);
  assign rid    = rid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

  always_comb begin
    w_state_d   = w_state_q;
    w_addr_d    = w_addr_q;
    w_rem_d     = w_rem_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we      = 1'b0;
    w_beat_resp = RESP_OKAY;
    w_exp_last  = 1'b0;
    w_acc       = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          bid_d     = awid;
          w_addr_d  = awaddr;
          w_rem_d   = awlen;
          bresp_d   = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          w_beat_resp = beat_resp(w_addr_q, err_inj_en, err_inj_addr, err_inj_resp);
          mem_we      = (w_beat_resp == RESP_OKAY);
          w_exp_last  = (w_rem_q == 8'd0);
          w_acc       = worst(bresp_q, w_beat_resp);
          // Early wlast or missing wlast on the expected last beat is a protocol error.
          if (wlast != w_exp_last) w_acc = worst(w_acc, RESP_SLVERR);
          bresp_d = w_acc;
          if (wlast || w_exp_last) begin
            w_state_d = W_RESP;
          end else begin
            w_addr_d = w_addr_q + STRIDE;
            w_rem_d  = w_rem_q - 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_rem_q   <= '0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_rem_q   <= w_rem_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign awready = (w_state_q == W_IDLE) && !areset;
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign w_idx   = w_addr_q[BYTE_LSB +: IDX_W];

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb2axi_axi_responder.sv
// tb/tb_apb2axi_axi_responder.sv - table-driven and randomized bench for apb2axi_axi_responder
module tb_apb2axi_axi_responder;
  localparam int TAG_W = 4, AXI_ADDR_W = 32, AXI_DATA_W = 32, MEM_WORDS = 64, AR_FIFO_DEPTH = 4;
  localparam int BYTES = AXI_DATA_W / 8;

  logic aclk = 1'b0;
  logic areset;
  logic [TAG_W-1:0] arid, rid, awid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata, err_inj_addr;
  logic [7:0] arlen, awlen;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready, err_inj_en;
  logic [1:0] rresp, bresp, err_inj_resp;

  always #5 aclk = ~aclk;

  apb2axi_axi_responder #(
    .TAG_W(TAG_W), .AXI_ADDR_W(AXI_ADDR_W), .AXI_DATA_W(AXI_DATA_W),
    .MEM_WORDS(MEM_WORDS), .AR_FIFO_DEPTH(AR_FIFO_DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .err_inj_en(err_inj_en), .err_inj_addr(err_inj_addr), .err_inj_resp(err_inj_resp)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] model_mem [MEM_WORDS];
  logic [1:0]  last_rresp [$];
  logic [31:0] last_rdata [$];

  typedef struct {
    bit          is_wr;
    logic [3:0]  id;
    logic [31:0] addr;
    int          len;
    int          nsent;
    bit          lastf;
    logic [3:0]  strb;
    logic [31:0] dseed;
    bit          inj;
    logic [31:0] inj_addr;
    logic [1:0]  inj_resp;
    int          chk_beat;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail(string name);
    n_checks++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endfunction

  function automatic logic [1:0] exp_resp(logic [31:0] a);
    if (a >= 32'(MEM_WORDS * BYTES)) return 2'b11;
    if (err_inj_en && a == err_inj_addr) return err_inj_resp;
    return 2'b00;
  endfunction

  function automatic int sev(logic [1:0] r);
    return (r == 2'b11) ? 2 : (r == 2'b10) ? 1 : 0;
  endfunction

  function automatic int midx(logic [31:0] a);
    return int'((a / BYTES) % MEM_WORDS);
  endfunction

  function automatic logic pick(int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return !rready;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_write(input logic [TAG_W-1:0] id, input logic [31:0] addr, input int len,
                          input int nsent, input bit lastf, input logic [3:0] strb,
                          input logic [31:0] dseed, output logic [1:0] bresp_act);
    int t;
    int wsev;
    int wi;
    logic [31:0] a;
    logic [1:0] r;
    bresp_act = 2'bxx;
    awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1; #1;
    t = 0;
    while (!awready && t < 50) begin @(negedge aclk); #1; t++; end
    if (!awready) begin fail("aw_wait"); awvalid = 1'b0; return; end
    @(negedge aclk); awvalid = 1'b0; #1;
    check("wready_after_aw", wready, 1);
    wsev = 0;
    for (int k = 0; k < nsent; k++) begin
      a = addr + 32'(k * BYTES);
      wdata = dseed * 32'(k + 1); wstrb = strb; wlast = lastf && (k == nsent - 1); wvalid = 1'b1; #1;
      t = 0;
      while (!wready && t < 50) begin @(negedge aclk); #1; t++; end
      if (!wready) begin fail("w_wait"); wvalid = 1'b0; wlast = 1'b0; return; end
      r = exp_resp(a);
      if (sev(r) > wsev) wsev = sev(r);
      if (r == 2'b00) begin
        wi = midx(a);
        for (int b = 0; b < BYTES; b++)
          if (strb[b]) model_mem[wi][8*b +: 8] = wdata[8*b +: 8];
      end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (!(nsent == len + 1 && lastf) && wsev < 1) wsev = 1;
    #1 check("bvalid_latency", bvalid, 1);
    t = 0;
    while (!bvalid && t < 50) begin @(negedge aclk); #1; t++; end
    if (!bvalid) begin fail("b_wait"); return; end
    check("bid", bid, id);
    check("bresp_model", bresp, (wsev == 2) ? 2'b11 : (wsev == 1) ? 2'b10 : 2'b00);
    bresp_act = bresp;
    bready = 1'b1;
    @(negedge aclk); bready = 1'b0; #1;
    check("awready_after_b", awready, 1);
  endtask

  task automatic issue_ar(input logic [TAG_W-1:0] id, input logic [31:0] addr, input int len);
    int t;
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1; #1;
    t = 0;
    while (!arready && t < 200) begin @(negedge aclk); #1; t++; end
    if (!arready) fail("ar_wait");
    @(negedge aclk); arvalid = 1'b0;
  endtask

  task automatic collect(input logic [TAG_W-1:0] id, input logic [31:0] addr, input int len,
                         input int mode);
    int t;
    bit snap;
    logic [31:0] a;
    logic [1:0] er;
    logic [31:0] ed;
    logic [63:0] sv;
    last_rresp.delete();
    last_rdata.delete();
    for (int k = 0; k <= len; k++) begin
      a = addr + 32'(k * BYTES);
      er = exp_resp(a);
      ed = (er == 2'b11) ? 32'h0 : model_mem[midx(a)];
      t = 0; snap = 1'b0; sv = '0;
      rready = pick(mode); #1;
      while (!(rvalid && rready) && t < 200) begin
        if (rvalid) begin
          if (snap) check("r_stable", {rid, rdata, rresp, rlast}, sv);
          sv = {25'b0, rid, rdata, rresp, rlast};
          snap = 1'b1;
        end
        @(negedge aclk); rready = pick(mode); #1; t++;
      end
      if (t >= 200) begin fail("r_wait"); rready = 1'b0; return; end
      if (snap) check("r_stable", {rid, rdata, rresp, rlast}, sv);
      check("rid", rid, id);
      check("rdata", rdata, ed);
      check("rresp", rresp, er);
      check("rlast", rlast, k == len);
      last_rresp.push_back(rresp);
      last_rdata.push_back(rdata);
      @(negedge aclk);
    end
    rready = 1'b0;
    #1 check("r_idle_gap", rvalid, 0);
  endtask

  task automatic do_read(input logic [TAG_W-1:0] id, input logic [31:0] addr, input int len,
                         input int mode);
    issue_ar(id, addr, len);
    #1 check("rvalid_n1", rvalid, 0);
    @(negedge aclk); #1 check("rvalid_n2", rvalid, 1);
    collect(id, addr, len, mode);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    logic [1:0] br;
    int acc;
    int t;
    int len;
    int nsent;
    bit lastf;

    areset = 1'b1;
    {arid, araddr, arlen, arvalid, rready, awid, awaddr, awlen, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready, err_inj_en, err_inj_addr, err_inj_resp} = '0;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;

    repeat (3) @(negedge aclk);
    #1;
    check("rst_rvalid", rvalid, 0);  check("rst_rlast", rlast, 0);
    check("rst_rid", rid, 0);        check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);    check("rst_bvalid", bvalid, 0);
    check("rst_bid", bid, 0);        check("rst_bresp", bresp, 0);
    check("rst_wready", wready, 0);  check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    @(negedge aclk); areset = 1'b0; #1;
    check("arready_after_rst", arready, 1);
    check("awready_after_rst", awready, 1);

    vecs.push_back('{1'b1, 4'd3,  32'h00, 3, 4, 1'b1, 4'hF, 32'h11,       1'b0, 32'h0,  2'b00, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 4'd5,  32'h00, 3, 0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,  2'b00, 3, 2'b00, 32'h44});
    vecs.push_back('{1'b0, 4'd1,  32'h00, 3, 0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h8,  2'b10, 2, 2'b10, 32'h33});
    vecs.push_back('{1'b0, 4'd2,  32'hFC, 1, 0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,  2'b00, 1, 2'b11, 32'h0});
    vecs.push_back('{1'b1, 4'd4,  32'hFC, 1, 2, 1'b1, 4'hF, 32'hA5,       1'b0, 32'h0,  2'b00, 0, 2'b11, 32'h0});
    vecs.push_back('{1'b0, 4'd6,  32'hFC, 0, 0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,  2'b00, 0, 2'b00, 32'hA5});
    vecs.push_back('{1'b1, 4'd7,  32'h20, 3, 2, 1'b1, 4'hF, 32'h1234,     1'b0, 32'h0,  2'b00, 0, 2'b10, 32'h0});
    vecs.push_back('{1'b1, 4'd8,  32'h00, 0, 1, 1'b1, 4'h1, 32'hDEADBEEF, 1'b0, 32'h0,  2'b00, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 4'd9,  32'h00, 0, 0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,  2'b00, 0, 2'b00, 32'hEF});
    vecs.push_back('{1'b1, 4'd10, 32'h40, 1, 2, 1'b0, 4'hF, 32'h77,       1'b0, 32'h0,  2'b00, 0, 2'b10, 32'h0});
    vecs.push_back('{1'b1, 4'd11, 32'h80, 1, 2, 1'b1, 4'hF, 32'h99,       1'b1, 32'h84, 2'b11, 0, 2'b11, 32'h0});
    vecs.push_back('{1'b0, 4'd12, 32'h80, 1, 0, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,  2'b00, 1, 2'b00, 32'h0});

    foreach (vecs[i]) begin
      err_inj_en = vecs[i].inj; err_inj_addr = vecs[i].inj_addr; err_inj_resp = vecs[i].inj_resp;
      if (vecs[i].is_wr) begin
        do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].nsent, vecs[i].lastf,
                 vecs[i].strb, vecs[i].dseed, br);
        check("vec_bresp", br, vecs[i].exp_resp);
      end else begin
        do_read(vecs[i].id, vecs[i].addr, vecs[i].len, i % 2);
        if (last_rresp.size() > vecs[i].chk_beat) begin
          check("vec_rresp", last_rresp[vecs[i].chk_beat], vecs[i].exp_resp);
          check("vec_rdata", last_rdata[vecs[i].chk_beat], vecs[i].exp_data);
        end else fail("vec_beats");
      end
    end
    err_inj_en = 1'b0;

    // AR queueing: one burst stalled in flight, then the FIFO takes exactly four more.
    rready = 1'b0;
    issue_ar(4'd0, 32'h0, 1);
    t = 0; #1;
    while (!rvalid && t < 10) begin @(negedge aclk); #1; t++; end
    acc = 0;
    for (int j = 1; j <= 5; j++) begin
      arid = 4'(j); araddr = 32'(j * 16); arlen = 8'(j % 3); arvalid = 1'b1; #1;
      if (arready) begin acc++; @(negedge aclk); end
      else break;
    end
    check("ar_fifo_accepts", acc, AR_FIFO_DEPTH);
    check("arready_when_full", arready, 0);
    arvalid = 1'b0;
    collect(4'd0, 32'h0, 1, 1);
    for (int j = 1; j <= 4; j++) collect(4'(j), 32'(j * 16), j % 3, 1);

    for (int it = 0; it < 60; it++) begin
      err_inj_en = ($urandom_range(0, 3) == 0);
      err_inj_addr = 32'($urandom_range(0, MEM_WORDS - 1) * BYTES);
      err_inj_resp = $urandom_range(0, 1) ? 2'b10 : 2'b11;
      len = $urandom_range(0, 3);
      if ($urandom_range(0, 1)) begin
        nsent = len + 1; lastf = 1'b1;
        if (len > 0 && $urandom_range(0, 3) == 0) nsent = $urandom_range(1, len);
        else if ($urandom_range(0, 3) == 0) lastf = 1'b0;
        do_write(4'($urandom), 32'($urandom_range(0, MEM_WORDS + 3) * BYTES), len, nsent, lastf,
                 4'($urandom), $urandom, br);
      end else begin
        do_read(4'($urandom), 32'($urandom_range(0, MEM_WORDS + 3) * BYTES), len, 2);
      end
    end
    err_inj_en = 1'b0;

    do_write(4'd1, 32'h0, 0, 1, 1'b1, 4'hF, 32'h5A5A5A5A, br);
    issue_ar(4'd1, 32'h0, 7);
    t = 0; #1;
    while (!rvalid && t < 10) begin @(negedge aclk); #1; t++; end
    rready = 1'b1;
    @(negedge aclk); @(negedge aclk);
    rready = 1'b0; areset = 1'b1;
    @(negedge aclk); #1;
    check("midrst_rvalid", rvalid, 0);
    check("midrst_rlast", rlast, 0);
    check("midrst_bvalid", bvalid, 0);
    check("midrst_arready", arready, 0);
    areset = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;
    #1 check("arready_after_midrst", arready, 1);
    do_read(4'd2, 32'h0, 0, 0);
    if (last_rdata.size() == 1) check("read_after_reset", last_rdata[0], 32'h0);
    else fail("read_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
